// File: rtl/updown_sweep_ctrl.sv
// Sequencer for an 8-bit up/down counter: loads lo, then sweeps lo->hi->lo n times.
// Optional SWEEP_HOLD_EN adds an i_hold input that freezes the run in LOAD/UP/DOWN.
module updown_sweep_ctrl #(
  parameter int WIDTH   = 8,
  parameter int SWEEP_W = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_abort,
`ifdef SWEEP_HOLD_EN
  input  logic               i_hold,
`endif
  input  logic [WIDTH-1:0]   i_lo,
  input  logic [WIDTH-1:0]   i_hi,
  input  logic [SWEEP_W-1:0] i_n_sweeps,
  input  logic [WIDTH-1:0]   i_count,
  output logic               o_cnt_load,
  output logic [WIDTH-1:0]   o_load_val,
  output logic               o_cnt_en,
  output logic               o_mode,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err,
  output logic [SWEEP_W-1:0] o_sweep_idx
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_UP   = 3'd2,
    S_DOWN = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_hi;
  logic [SWEEP_W-1:0] r_n;
  logic [SWEEP_W-1:0] r_sweep_idx;
  logic               r_err;

  logic               w_hold;
  logic               w_go;
  logic               w_start_req;
  logic               w_start_ok;
  logic               w_at_hi;
  logic               w_at_lo;
  logic [SWEEP_W-1:0] w_idx_inc;
  logic               w_last;

`ifdef SWEEP_HOLD_EN
  assign w_hold = i_hold;
`else
  assign w_hold = 1'b0;
`endif

  // abort outranks start, so an aborted start is neither accepted nor rejected
  assign w_start_req = i_start && !i_abort;
  assign w_start_ok  = w_start_req && (i_lo < i_hi) && (i_n_sweeps != '0);
  assign w_go        = !w_hold && !i_abort;
  assign w_at_hi     = (i_count == r_hi);
  assign w_at_lo     = (i_count == r_lo);
  assign w_idx_inc   = r_sweep_idx + {{(SWEEP_W-1){1'b0}}, 1'b1};
  assign w_last      = (w_idx_inc == r_n);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_start_ok) w_next = S_LOAD;
      S_LOAD: if (!w_hold) w_next = S_UP;
      S_UP:   if (!w_hold && w_at_hi) w_next = S_DOWN;
      S_DOWN: if (!w_hold && w_at_lo) w_next = w_last ? S_DONE : S_UP;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (i_abort && (r_state != S_IDLE)) w_next = S_IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lo        <= '0;
      r_hi        <= '0;
      r_n         <= '0;
      r_sweep_idx <= '0;
      r_err       <= 1'b0;
    end else begin
      r_err <= (r_state == S_IDLE) && w_start_req && !w_start_ok;
      if ((r_state == S_IDLE) && w_start_ok) begin
        r_lo        <= i_lo;
        r_hi        <= i_hi;
        r_n         <= i_n_sweeps;
        r_sweep_idx <= '0;
      end else if ((r_state == S_DOWN) && w_go && w_at_lo) begin
        r_sweep_idx <= w_idx_inc;
      end
    end
  end

  always_comb begin
    o_cnt_load = 1'b0;
    o_cnt_en   = 1'b0;
    o_mode     = 1'b0;
    o_done     = 1'b0;
    case (r_state)
      S_LOAD: o_cnt_load = w_go;
      S_UP: begin
        o_cnt_en = w_go;
        o_mode   = w_at_hi;
      end
      S_DOWN: begin
        // at lo the direction flips to up unless this was the final sweep
        o_cnt_en = w_go && !(w_at_lo && w_last);
        o_mode   = !w_at_lo;
      end
      S_DONE: o_done = !i_abort;
      default: ;
    endcase
    if (i_rst) begin
      o_cnt_load = 1'b0;
      o_cnt_en   = 1'b0;
      o_done     = 1'b0;
    end
  end

  assign o_busy      = (r_state != S_IDLE);
  assign o_err       = r_err;
  assign o_load_val  = r_lo;
  assign o_sweep_idx = r_sweep_idx;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Self-checking bench for updown_sweep_ctrl: a behavioural counter plus a per-cycle
// expected count/sweep trace derived from lo, hi and n.
module tb_updown_sweep_ctrl;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_start = 1'b0;
  logic       i_abort = 1'b0;
`ifdef SWEEP_HOLD_EN
  logic       i_hold = 1'b0;
`endif
  logic [7:0] i_lo = 8'd0;
  logic [7:0] i_hi = 8'd0;
  logic [3:0] i_n = 4'd0;
  logic [7:0] count = 8'd0;
  logic       o_cnt_load, o_cnt_en, o_mode, o_busy, o_done, o_err;
  logic [7:0] o_load_val;
  logic [3:0] o_sweep_idx;

  int checks = 0;
  int errors = 0;
  int exp_cnt[$];
  int exp_idx[$];

  always #5 i_clk = ~i_clk;

  // counter being sequenced: load beats enable, mode=1 counts down
  always @(posedge i_clk) begin
    if (o_cnt_load) count <= o_load_val;
    else if (o_cnt_en) count <= o_mode ? count - 8'd1 : count + 8'd1;
  end

  updown_sweep_ctrl #(.WIDTH(8), .SWEEP_W(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort),
`ifdef SWEEP_HOLD_EN
    .i_hold(i_hold),
`endif
    .i_lo(i_lo), .i_hi(i_hi), .i_n_sweeps(i_n), .i_count(count),
    .o_cnt_load(o_cnt_load), .o_load_val(o_load_val), .o_cnt_en(o_cnt_en),
    .o_mode(o_mode), .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .o_sweep_idx(o_sweep_idx)
  );

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Triangle waveform seen on count from the first UP cycle up to the final lo,
  // together with the number of sweeps already completed in each of those cycles.
  task automatic build_trace(input int lo, input int hi, input int n);
    exp_cnt.delete();
    exp_idx.delete();
    for (int s = 0; s < n; s++) begin
      for (int v = (s == 0) ? lo : lo + 1; v <= hi; v++) begin
        exp_cnt.push_back(v);
        exp_idx.push_back(s);
      end
      for (int v = hi - 1; v >= lo; v--) begin
        exp_cnt.push_back(v);
        exp_idx.push_back(s);
      end
    end
  endtask

  task automatic run_sweep(input int lo, input int hi, input int n, input bit spam,
                           input int hold_at);
    build_trace(lo, hi, n);
    i_lo = 8'(lo); i_hi = 8'(hi); i_n = 4'(n); i_start = 1'b1;
    step();
    i_start = 1'b0;
    @(negedge i_clk);
    checks++;
    if ({o_busy, o_cnt_load, o_cnt_en} !== 3'b110 || int'(o_load_val) != lo) begin
      errors++;
      $display("FAIL load_cycle busy/load/en=%b%b%b load_val=%0d required 110 %0d",
               o_busy, o_cnt_load, o_cnt_en, o_load_val, lo);
    end
    step();
    for (int k = 0; k < exp_cnt.size(); k++) begin
`ifdef SWEEP_HOLD_EN
      if (k == hold_at) begin
        repeat (3) begin
          i_hold = 1'b1;
          @(negedge i_clk);
          checks++;
          if (int'(count) != exp_cnt[k] || o_cnt_en !== 1'b0 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL hold k=%0d count=%0d en=%b busy=%b required %0d 0 1",
                     k, count, o_cnt_en, o_busy, exp_cnt[k]);
          end
          step();
        end
        i_hold = 1'b0;
      end
`endif
      if (spam) begin
        i_start = 1'($urandom_range(0, 1));
        i_lo = 8'($urandom); i_hi = 8'($urandom); i_n = 4'($urandom);
      end
      @(negedge i_clk);
      checks++;
      if (int'(count) != exp_cnt[k]) begin
        errors++;
        $display("FAIL trace_count k=%0d count=%0d required %0d", k, count, exp_cnt[k]);
      end
      checks++;
      if (int'(o_sweep_idx) != exp_idx[k]) begin
        errors++;
        $display("FAIL trace_idx k=%0d sweep_idx=%0d required %0d", k, o_sweep_idx, exp_idx[k]);
      end
      checks++;
      if (o_cnt_en !== (k != exp_cnt.size() - 1) || {o_busy, o_done, o_err, o_cnt_load} !== 4'b1000
          || int'(o_load_val) != lo) begin
        errors++;
        $display("FAIL trace_ctrl k=%0d en=%b busy/done/err/load=%b%b%b%b load_val=%0d required en=%b 1000 %0d",
                 k, o_cnt_en, o_busy, o_done, o_err, o_cnt_load, o_load_val,
                 (k != exp_cnt.size() - 1), lo);
      end
      step();
    end
    i_start = 1'b0;
    @(negedge i_clk);
    checks++;
    if ({o_done, o_busy, o_cnt_en} !== 3'b110 || int'(count) != lo || int'(o_sweep_idx) != n) begin
      errors++;
      $display("FAIL done_cycle done/busy/en=%b%b%b count=%0d idx=%0d required 110 %0d %0d",
               o_done, o_busy, o_cnt_en, count, o_sweep_idx, lo, n);
    end
    step();
    @(negedge i_clk);
    checks++;
    if ({o_done, o_busy, o_err} !== 3'b000 || int'(count) != lo) begin
      errors++;
      $display("FAIL after_done done/busy/err=%b%b%b count=%0d required 000 %0d",
               o_done, o_busy, o_err, count, lo);
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (2) step();
    @(negedge i_clk);
    checks++;
    if ({o_busy, o_done, o_err, o_cnt_en, o_cnt_load} !== 5'b0 || o_sweep_idx !== 4'd0
        || o_load_val !== 8'd0) begin
      errors++;
      $display("FAIL reset busy/done/err/en/load=%b%b%b%b%b idx=%0d load_val=%0d required all 0",
               o_busy, o_done, o_err, o_cnt_en, o_cnt_load, o_sweep_idx, o_load_val);
    end
    i_rst = 1'b0;
    step();
  endtask

  task automatic test_reject(input int lo, input int hi, input int n, input bit with_abort);
    i_lo = 8'(lo); i_hi = 8'(hi); i_n = 4'(n); i_start = 1'b1; i_abort = with_abort;
    step();
    i_start = 1'b0; i_abort = 1'b0;
    @(negedge i_clk);
    checks++;
    if (o_err !== !with_abort || o_busy !== 1'b0 || o_cnt_load !== 1'b0) begin
      errors++;
      $display("FAIL reject lo=%0d hi=%0d n=%0d err=%b busy=%b load=%b required %b 0 0",
               lo, hi, n, o_err, o_busy, o_cnt_load, !with_abort);
    end
    step();
    @(negedge i_clk);
    checks++;
    if (o_err !== 1'b0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL reject_pulse err=%b busy=%b required 0 0", o_err, o_busy);
    end
    step();
  endtask

  // abort (or reset) asserted on trace cycle k; the run must stop with count frozen
  task automatic test_abort(input int lo, input int hi, input int n, input int k, input bit use_rst);
    build_trace(lo, hi, n);
    i_lo = 8'(lo); i_hi = 8'(hi); i_n = 4'(n); i_start = 1'b1;
    step();
    i_start = 1'b0;
    step();
    for (int j = 0; j < k; j++) step();
    if (use_rst) i_rst = 1'b1; else i_abort = 1'b1;
    @(negedge i_clk);
    checks++;
    if (o_cnt_en !== 1'b0 || o_done !== 1'b0 || int'(count) != exp_cnt[k]) begin
      errors++;
      $display("FAIL abort_cycle k=%0d en=%b done=%b count=%0d required 0 0 %0d",
               k, o_cnt_en, o_done, count, exp_cnt[k]);
    end
    step();
    i_rst = 1'b0; i_abort = 1'b0;
    repeat (2) begin
      @(negedge i_clk);
      checks++;
      if (o_busy !== 1'b0 || o_done !== 1'b0 || int'(count) != exp_cnt[k]
          || int'(o_sweep_idx) != (use_rst ? 0 : exp_idx[k])) begin
        errors++;
        $display("FAIL after_abort busy=%b done=%b count=%0d idx=%0d required 0 0 %0d %0d",
                 o_busy, o_done, count, o_sweep_idx, exp_cnt[k], use_rst ? 0 : exp_idx[k]);
      end
      step();
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      int lo, hi, n;
      lo = $urandom_range(0, 230);
      hi = lo + $urandom_range(1, 20);
      n  = $urandom_range(1, 4);
      run_sweep(lo, hi, n, 1'b1, -1);
      step();
    end
  endtask

  initial begin
    test_reset();
    run_sweep(2, 5, 1, 1'b0, -1);
    step();
    run_sweep(0, 3, 3, 1'b0, -1);
    step();
    test_reject(7, 7, 1, 1'b0);
    test_reject(3, 9, 0, 1'b0);
    test_reject(200, 12, 2, 1'b0);
    test_reject(2, 5, 1, 1'b1);
    test_abort(2, 5, 1, 3, 1'b0);
    run_sweep(2, 5, 1, 1'b0, -1);
    step();
    test_abort(1, 4, 2, 10, 1'b0);
    test_abort(0, 9, 1, 5, 1'b1);
    run_sweep(0, 255, 1, 1'b0, -1);
    step();
    test_random();
`ifdef SWEEP_HOLD_EN
    run_sweep(2, 8, 1, 1'b0, 2);
    step();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
